// File: rtl/psum_accum_buffer_if.sv
// Control, psum stream and readback bundle for the partial-sum buffer.
interface psum_accum_buffer_if #(
  parameter int LANES   = 32,
  parameter int PSUM_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int BATCH_W = 6,
  parameter int LANE_W  = 5
);
  logic                    start;
  logic                    accumulate;
  logic [ADDR_W-1:0]       address_start;
  logic [BATCH_W-1:0]      batch;
  logic [LANE_W-1:0]       last_col;
  logic [LANES*PSUM_W-1:0] partialsum_out;
  logic [LANES-1:0]        partialsum_out_valid;
  logic                    s_en;
  logic [ADDR_W-1:0]       s_addr;
  logic [LANES*PSUM_W-1:0] s_dout;
  logic                    busy;
  logic                    done;
  logic                    sat_flag;

  modport master (
    output start, accumulate, address_start, batch, last_col,
           partialsum_out, partialsum_out_valid, s_en, s_addr,
    input  s_dout, busy, done, sat_flag
  );

  modport slave (
    input  start, accumulate, address_start, batch, last_col,
           partialsum_out, partialsum_out_valid, s_en, s_addr,
    output s_dout, busy, done, sat_flag
  );
endinterface

// File: rtl/psum_accum_buffer.sv
// Banked partial-sum buffer: one RAM bank plus a 2-stage RMW pipe per lane,
// a pass-level FSM, and a shared-address readback port.

// One lane: row counter, bank RAM, read-modify-write with signed saturation.
module psum_accum_lane #(
  parameter int PSUM_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int BATCH_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               run,
  input  logic               act,
  input  logic               accum,
  input  logic [ADDR_W-1:0]  base,
  input  logic [BATCH_W-1:0] batch,
  input  logic [PSUM_W-1:0]  psum,
  input  logic               vld,
  input  logic               host_rd,
  input  logic [ADDR_W-1:0]  host_addr,
  output logic               fin,
  output logic               sat,
  output logic [PSUM_W-1:0]  dout
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [BATCH_W-1:0] ROW_ONE = 1;
  localparam logic [PSUM_W-1:0] PMAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] PMIN = {1'b1, {(PSUM_W-1){1'b0}}};

  logic [PSUM_W-1:0]  mem [DEPTH];
  logic [BATCH_W-1:0] row;
  logic               acc0;
  logic [ADDR_W-1:0]  addr0;
  logic               s1_vld;
  logic [ADDR_W-1:0]  s1_addr;
  logic [PSUM_W-1:0]  s1_psum;
  logic [PSUM_W-1:0]  rd_q;
  logic               host_pend;
  logic [PSUM_W-1:0]  hold;
  logic [PSUM_W:0]    sum;
  logic               ovf;
  logic [PSUM_W-1:0]  wdata;
  logic               re;
  logic [ADDR_W-1:0]  raddr;

  assign acc0  = run && vld && act && (row < batch);
  assign addr0 = base + ADDR_W'(row);
  assign fin   = !act || (row >= batch);

  // Bank read port: RMW owns it while running, otherwise the host.
  assign re    = acc0 || host_rd;
  assign raddr = acc0 ? addr0 : host_addr;

  // S1 arithmetic: widen by one bit, clamp on signed overflow.
  assign sum   = {rd_q[PSUM_W-1], rd_q} + {s1_psum[PSUM_W-1], s1_psum};
  assign ovf   = sum[PSUM_W] ^ sum[PSUM_W-1];
  assign wdata = !accum ? s1_psum : (ovf ? (sum[PSUM_W] ? PMIN : PMAX) : sum[PSUM_W-1:0]);
  assign sat   = s1_vld && accum && ovf;

  // Readback holds its last value unless a fresh host read just landed.
  assign dout  = host_pend ? rd_q : hold;

  // Per-lane row counter, cleared at pass start.
  always_ff @(posedge clk) begin
    if (reset)     row <= '0;
    else if (clr)  row <= '0;
    else if (acc0) row <= row + ROW_ONE;
  end

  // Pipeline valid and host-read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      host_pend <= 1'b0;
      hold      <= '0;
    end else begin
      s1_vld    <= acc0;
      host_pend <= host_rd;
      hold      <= dout;
    end
  end

  // S0 -> S1 payload, no reset needed behind the valid.
  always_ff @(posedge clk) begin
    s1_addr <= addr0;
    s1_psum <= psum;
  end

  // Synchronous bank read.
  always_ff @(posedge clk) begin
    if (re) rd_q <= mem[raddr];
  end

  // Bank write at end of S1.
  always_ff @(posedge clk) begin
    if (s1_vld) mem[s1_addr] <= wdata;
  end
endmodule

module psum_accum_buffer #(
  parameter int LANES   = 32,
  parameter int PSUM_W  = 16,
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int BATCH_W = 6,
  parameter int LANE_W  = $clog2(LANES)
) (
  input logic clk,
  input logic reset,
  psum_accum_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state, state_nx;
  logic                           dcnt;
  logic                           start_ok;
  logic                           busy_w;
  logic                           accum_q;
  logic [ADDR_W-1:0]              base_q;
  logic [BATCH_W-1:0]             batch_q;
  logic [LANE_W-1:0]              last_col_q;
  logic [LANES-1:0]               fin;
  logic [LANES-1:0]               sat;
  logic [LANES-1:0][PSUM_W-1:0]   dout_a;

  assign start_ok   = bus.start && (state == IDLE);
  assign bus.s_dout = dout_a;
  assign bus.busy   = busy_w;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; an empty batch skips RUN entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.batch == '0) ? DRAIN : RUN;
      RUN:     if (&fin) state_nx = DRAIN;
      DRAIN:   if (dcnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy_w   = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Two-cycle drain timer lets the last RMW write land.
  always_ff @(posedge clk) begin
    if (reset)               dcnt <= 1'b0;
    else if (state == DRAIN) dcnt <= ~dcnt;
    else                     dcnt <= 1'b0;
  end

  // Pass configuration latched on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      accum_q    <= 1'b0;
      base_q     <= '0;
      batch_q    <= '0;
      last_col_q <= '0;
    end else if (start_ok) begin
      accum_q    <= bus.accumulate;
      base_q     <= bus.address_start;
      batch_q    <= bus.batch;
      last_col_q <= bus.last_col;
    end
  end

  // Sticky saturation flag, cleared when a pass starts.
  always_ff @(posedge clk) begin
    if (reset)         bus.sat_flag <= 1'b0;
    else if (start_ok) bus.sat_flag <= 1'b0;
    else if (|sat)     bus.sat_flag <= 1'b1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_accum_lane #(
      .PSUM_W (PSUM_W),
      .ADDR_W (ADDR_W),
      .BATCH_W(BATCH_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr      (start_ok),
      .run      (state == RUN),
      .act      (LANE_W'(i) <= last_col_q),
      .accum    (accum_q),
      .base     (base_q),
      .batch    (batch_q),
      .psum     (bus.partialsum_out[i*PSUM_W +: PSUM_W]),
      .vld      (bus.partialsum_out_valid[i]),
      .host_rd  (bus.s_en && !busy_w),
      .host_addr(bus.s_addr),
      .fin      (fin[i]),
      .sat      (sat[i]),
      .dout     (dout_a[i])
    );
  end
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench for psum_accum_buffer: overwrite, accumulate, skew, saturation/wrap, edges, reset.
module tb_psum_accum_buffer;
  localparam int L = 32;
  localparam int W = 16;
  typedef logic [L*W-1:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n;

  always #5 clk = ~clk;

  psum_accum_buffer_if #(.LANES(L), .PSUM_W(W), .ADDR_W(11), .BATCH_W(6), .LANE_W(5)) ifc ();

  psum_accum_buffer u_dut (.clk(clk), .reset(reset), .bus(ifc));

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane i = ki*i + c
  function automatic vec_t mk(input int ki, input int c);
    vec_t v;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(ki*i + c);
    return v;
  endfunction

  task automatic start_pass(input logic acc, input int base, input int b, input int lc);
    ifc.start         = 1'b1;
    ifc.accumulate    = acc;
    ifc.address_start = 11'(base);
    ifc.batch         = 6'(b);
    ifc.last_col      = 5'(lc);
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic drive(input vec_t p, input logic [L-1:0] v);
    ifc.partialsum_out       = p;
    ifc.partialsum_out_valid = v;
    tick();
  endtask

  task automatic wait_done(output int cnt);
    ifc.partialsum_out_valid = '0;
    cnt = 0;
    repeat (20) begin
      tick();
      if (ifc.done) cnt++;
    end
  endtask

  task automatic rd(input int a);
    ifc.s_en   = 1'b1;
    ifc.s_addr = 11'(a);
    tick();
    ifc.s_en = 1'b0;
  endtask

  initial begin
    vec_t p;
    logic [L-1:0] v;
    int early;

    ifc.start = 1'b0; ifc.accumulate = 1'b0; ifc.address_start = '0; ifc.batch = '0;
    ifc.last_col = '0; ifc.partialsum_out = '0; ifc.partialsum_out_valid = '0;
    ifc.s_en = 1'b0; ifc.s_addr = '0;

    // reset state
    repeat (3) tick();
    chk("rst_busy", ifc.busy, '0);
    chk("rst_done", ifc.done, '0);
    chk("rst_sat", ifc.sat_flag, '0);
    chk("rst_dout", ifc.s_dout, '0);
    reset = 1'b0;
    tick();

    // 1: overwrite
    start_pass(1'b0, 10, 4, 31);
    chk("t1_busy_run", ifc.busy, 1'b1);
    for (int r = 0; r < 4; r++) drive(mk(4, r), '1);
    wait_done(n);
    chk("t1_done_cnt", n, 1);
    chk("t1_busy_end", ifc.busy, '0);
    for (int r = 0; r < 4; r++) begin
      rd(10 + r);
      chk($sformatf("t1_rd%0d", r), ifc.s_dout, mk(4, r));
    end

    // 2: accumulate same data
    start_pass(1'b1, 10, 4, 31);
    for (int r = 0; r < 4; r++) drive(mk(4, r), '1);
    wait_done(n);
    chk("t2_done_cnt", n, 1);
    chk("t2_sat", ifc.sat_flag, '0);
    for (int r = 0; r < 4; r++) begin
      rd(10 + r);
      chk($sformatf("t2_rd%0d", r), ifc.s_dout, mk(8, 2*r));
    end

    // 3: skew, inactive lanes; preload 0x55 at 100..101 first
    start_pass(1'b0, 100, 2, 31);
    drive(mk(0, 85), '1);
    drive(mk(0, 85), '1);
    wait_done(n);
    start_pass(1'b0, 100, 2, 3);
    early = 0;
    for (int c = 0; c < 6; c++) begin
      p = '0; v = '0;
      for (int k = 0; k < 4; k++) begin
        if (c >= k && c < k + 2) v[k] = 1'b1;
        if (c >= k) p[k*W +: W] = W'(1000 + 10*k + c - k);
      end
      v[0] = 1'b1;
      v[7] = 1'b1;
      p[7*W +: W] = 16'h0777;
      drive(p, v);
      if (ifc.done) early++;
    end
    chk("t3_no_early_done", early, 0);
    wait_done(n);
    chk("t3_done_cnt", n, 1);
    for (int r = 0; r < 2; r++) begin
      p = mk(0, 85);
      for (int k = 0; k < 4; k++) p[k*W +: W] = W'(1000 + 10*k + r);
      rd(100 + r);
      chk($sformatf("t3_rd%0d", r), ifc.s_dout, p);
    end

    // 4: saturation across address wrap; addr 1 preloaded with 7
    start_pass(1'b0, 2046, 4, 31);
    drive(mk(0, 32000), '1);
    drive(mk(0, 32000), '1);
    drive(mk(0, 32000), '1);
    drive(mk(0, 7), '1);
    wait_done(n);
    start_pass(1'b1, 2046, 3, 31);
    for (int r = 0; r < 3; r++) drive(mk(0, 1000), '1);
    wait_done(n);
    chk("t4_done_cnt", n, 1);
    chk("t4_sat", ifc.sat_flag, 1'b1);
    rd(2046); chk("t4_rd2046", ifc.s_dout, mk(0, 32767));
    rd(2047); chk("t4_rd2047", ifc.s_dout, mk(0, 32767));
    rd(0);    chk("t4_rd0", ifc.s_dout, mk(0, 32767));
    rd(1);    chk("t4_rd1", ifc.s_dout, mk(0, 7));

    // 5a: batch=0, valids present but nothing written
    ifc.partialsum_out = mk(0, 16'h1234);
    ifc.partialsum_out_valid = '1;
    start_pass(1'b0, 10, 0, 31);
    chk("t5_sat_clr", ifc.sat_flag, '0);
    chk("t5_busy", ifc.busy, 1'b1);
    chk("t5_done_c1", ifc.done, '0);
    tick();
    chk("t5_done_c2", ifc.done, '0);
    tick();
    chk("t5_done_c3", ifc.done, 1'b1);
    tick();
    chk("t5_done_c4", ifc.done, '0);
    chk("t5_idle", ifc.busy, '0);
    ifc.partialsum_out_valid = '0;
    rd(10);
    chk("t5_nowrite", ifc.s_dout, mk(8, 0));

    // 5b: start and s_en while busy are ignored
    start_pass(1'b0, 200, 2, 31);
    ifc.start = 1'b1; ifc.accumulate = 1'b1; ifc.address_start = 11'd300; ifc.batch = 6'd1;
    ifc.s_en = 1'b1; ifc.s_addr = 11'd11;
    drive(mk(0, 256), '1);
    ifc.start = 1'b0;
    chk("t5_hold1", ifc.s_dout, mk(8, 0));
    drive(mk(0, 257), '1);
    ifc.s_en = 1'b0;
    chk("t5_hold2", ifc.s_dout, mk(8, 0));
    wait_done(n);
    chk("t5_done_cnt", n, 1);
    rd(200); chk("t5_rd200", ifc.s_dout, mk(0, 256));
    rd(201); chk("t5_rd201", ifc.s_dout, mk(0, 257));

    // 6: reset mid-RUN, then a clean pass
    start_pass(1'b0, 400, 4, 31);
    drive(mk(0, 16'h4000), '1);
    drive(mk(0, 16'h4001), '1);
    ifc.partialsum_out_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", ifc.busy, '0);
    chk("t6_dout", ifc.s_dout, '0);
    wait_done(n);
    chk("t6_no_done", n, 0);
    start_pass(1'b0, 400, 4, 31);
    for (int r = 0; r < 4; r++) drive(mk(3, 16'h0600 + r), '1);
    wait_done(n);
    chk("t6_done_cnt", n, 1);
    for (int r = 0; r < 4; r++) begin
      rd(400 + r);
      chk($sformatf("t6_rd%0d", r), ifc.s_dout, mk(3, 16'h0600 + r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
